spi_xfer_ctrl: RTL and testbench

//  Sequences one SPI master transfer of DW bits, stepping on the one-Clk Pulse tick from the prescaler.
//  - Programs the prescaler's CPre from Div at transfer start.
//  - Drives CS_n/SCK/MOSI, samples MISO, returns the received word with a one-cycle Done.
//  - Sits between the register/host side and the SPI pins, alongside the pulse generator.

---
 rtl/spi_xfer_ctrl_if.sv | 28 ++
 rtl/spi_xfer_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_if.sv
// rtl/spi_xfer_ctrl_if.sv - host/pin-side signal bundle of the SPI transfer controller
interface spi_xfer_ctrl_if #(
  parameter int DW   = 8,
  parameter int SIZE = 4
);
  logic            Pulse;
  logic            Start;
  logic [SIZE-1:0] Div;
  logic [DW-1:0]   TxData;
  logic            MISO;
  logic [SIZE-1:0] CPre;
  logic            SCK;
  logic            MOSI;
  logic            CS_n;
  logic            Busy;
  logic            Done;
  logic [DW-1:0]   RxData;

  modport slave (
    input  Pulse, Start, Div, TxData, MISO,
    output CPre, SCK, MOSI, CS_n, Busy, Done, RxData
  );

  modport master (
    output Pulse, Start, Div, TxData, MISO,
    input  CPre, SCK, MOSI, CS_n, Busy, Done, RxData
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - one SPI master transfer of DW bits, advanced by prescaler ticks
module spi_xfer_ctrl #(
  parameter int DW   = 8,
  parameter int SIZE = 4,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  spi_xfer_ctrl_if.slave    bus
);
  localparam int CW = $clog2(2*DW) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   tx_q, tx_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic [DW-1:0]   rxd_q, rxd_d;
  logic [SIZE-1:0] cpre_q, cpre_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;

  logic [CW-1:0]   edge_n;
  logic            leading;
  logic            last_edge;

  // edge_n is the number of the SCK edge this tick would produce
  assign edge_n    = cnt_q + 1'b1;
  assign leading   = edge_n[0];
  assign last_edge = (cnt_q == CW'(2*DW));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      cpre_q  <= '0;
      sck_q   <= CPOL;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      cpre_q  <= cpre_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    cpre_d  = cpre_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = SETUP;
          tx_d    = bus.TxData;
          cpre_d  = bus.Div;
          if (CPHA == 1'b0) mosi_d = bus.TxData[DW-1];
        end
      end
      SETUP: begin
        if (bus.Pulse) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bus.Pulse) begin
          if (last_edge) begin
            state_d = HOLD;
          end else begin
            sck_d = ~sck_q;
            cnt_d = edge_n;
            if (leading) begin
              if (CPHA == 1'b0) begin
                rx_d = {rx_q[DW-2:0], bus.MISO};
              end else begin
                mosi_d = tx_q[DW-1];
                tx_d   = tx_q << 1;
              end
            end else begin
              if (CPHA == 1'b1) begin
                rx_d = {rx_q[DW-2:0], bus.MISO};
              end else if (edge_n != CW'(2*DW)) begin
                // Bit DW-1 was presented at start, so the trailing edge exposes the next one
                mosi_d = tx_q[DW-2];
                tx_d   = tx_q << 1;
              end
            end
          end
        end
      end
      HOLD: begin
        if (bus.Pulse) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rxd_d   = rx_q;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.CPre   = cpre_q;
  assign bus.SCK    = sck_q;
  assign bus.MOSI   = mosi_q;
  assign bus.CS_n   = (state_q == IDLE);
  assign bus.Busy   = (state_q != IDLE);
  assign bus.Done   = done_q;
  assign bus.RxData = rxd_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - scoreboard bench for spi_xfer_ctrl in mode 0 and mode 3
module tb_spi_xfer_ctrl;
  localparam int DW   = 8;
  localparam int SIZE = 4;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  spi_xfer_ctrl_if #(.DW(DW), .SIZE(SIZE)) b0 ();
  spi_xfer_ctrl_if #(.DW(DW), .SIZE(SIZE)) b3 ();

  spi_xfer_ctrl #(.DW(DW), .SIZE(SIZE), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(b0.slave));
  spi_xfer_ctrl #(.DW(DW), .SIZE(SIZE), .CPOL(1'b1), .CPHA(1'b1)) u3 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(b3.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } exp_t;
  exp_t q0[$];
  exp_t q3[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0 slave is a plain loopback
  assign b0.MISO = b0.MOSI;

  int gap_mode = 0;
  int gap_cnt  = 0;
  always @(negedge Clk) begin
    if (gap_mode == 0) begin
      b0.Pulse = 1'b1;
    end else if (gap_cnt == 0) begin
      b0.Pulse = 1'b1;
      gap_cnt  = $urandom_range(0, 6);
    end else begin
      b0.Pulse = 1'b0;
      gap_cnt--;
    end
  end

  int pc3 = 0;
  always @(negedge Clk) begin
    if (pc3 >= int'(b3.CPre)) begin
      b3.Pulse = 1'b1;
      pc3      = 0;
    end else begin
      b3.Pulse = 1'b0;
      pc3++;
    end
  end

  logic          p_pulse0, p_sck0, p_mosi0, p_cs0, p_done0;
  int            ticks0, rises0, done_cnt0;
  logic [DW-1:0] stream0;
  exp_t          e0;
  initial done_cnt0 = 0;

  always @(posedge Clk) begin
    p_pulse0 = b0.Pulse;
    p_cs0    = b0.CS_n;
    p_sck0   = b0.SCK;
    p_mosi0  = b0.MOSI;
    #1;
    if (!Rst_n) begin
      ticks0 = 0; rises0 = 0; stream0 = '0; p_done0 = 1'b0;
    end else begin
      if (!p_cs0 && p_pulse0) ticks0++;
      if (!p_cs0 && !p_pulse0) chk("hold0", {b0.SCK, b0.MOSI}, {p_sck0, p_mosi0});
      if (b0.SCK !== p_sck0 && b0.SCK === 1'b1) begin
        rises0++;
        stream0 = {stream0[DW-2:0], b0.MOSI};
      end
      if (b0.Done === 1'b1) begin
        done_cnt0++;
        chk("done_single0", 32'(p_done0), 0);
        if (q0.size() == 0) begin
          chk("unexpected_done0", 1, 0);
        end else begin
          e0 = q0.pop_front();
          chk("rx0", b0.RxData, e0.rx);
          chk("mosi_stream0", stream0, e0.tx);
          chk("sck_rises0", rises0, DW);
          chk("cs_ticks0", ticks0, 2*DW+3);
          chk("sck_idle0", b0.SCK, 0);
        end
        ticks0 = 0; rises0 = 0; stream0 = '0;
      end
      p_done0 = b0.Done;
    end
  end

  logic          p_pulse3, p_sck3, p_mosi3, p_cs3, p_done3;
  int            ticks3, rises3, done_cnt3, bit3;
  logic [DW-1:0] stream3, sw3;
  exp_t          e3;
  initial done_cnt3 = 0;

  always @(posedge Clk) begin
    p_pulse3 = b3.Pulse;
    p_cs3    = b3.CS_n;
    p_sck3   = b3.SCK;
    p_mosi3  = b3.MOSI;
    #1;
    if (!Rst_n) begin
      ticks3 = 0; rises3 = 0; stream3 = '0; p_done3 = 1'b0; bit3 = 0;
      b3.MISO = 1'b0;
    end else begin
      if (b3.CS_n === 1'b1) bit3 = 0;
      if (!p_cs3 && p_pulse3) ticks3++;
      if (!p_cs3 && !p_pulse3) chk("hold3", {b3.SCK, b3.MOSI}, {p_sck3, p_mosi3});
      if (b3.SCK !== p_sck3 && b3.SCK === 1'b0 && bit3 < DW) begin
        b3.MISO = sw3[DW-1-bit3];
        bit3++;
      end
      if (b3.SCK !== p_sck3 && b3.SCK === 1'b1) begin
        rises3++;
        stream3 = {stream3[DW-2:0], b3.MOSI};
      end
      if (b3.Done === 1'b1) begin
        done_cnt3++;
        chk("done_single3", 32'(p_done3), 0);
        if (q3.size() == 0) begin
          chk("unexpected_done3", 1, 0);
        end else begin
          e3 = q3.pop_front();
          chk("rx3", b3.RxData, e3.rx);
          chk("mosi_stream3", stream3, e3.tx);
          chk("sck_rises3", rises3, DW);
          chk("cs_ticks3", ticks3, 2*DW+3);
          chk("sck_idle3", b3.SCK, 1);
        end
        ticks3 = 0; rises3 = 0; stream3 = '0;
      end
      p_done3 = b3.Done;
    end
  end

  task automatic start0(input logic [DW-1:0] tx);
    exp_t e;
    @(negedge Clk);
    b0.TxData = tx; b0.Div = '0; b0.Start = 1'b1;
    e.tx = tx; e.rx = tx;
    q0.push_back(e);
    @(negedge Clk);
    b0.Start = 1'b0;
  endtask

  task automatic start3(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input logic [SIZE-1:0] div);
    exp_t e;
    @(negedge Clk);
    sw3 = sw;
    b3.TxData = tx; b3.Div = div; b3.Start = 1'b1;
    e.tx = tx; e.rx = sw;
    q3.push_back(e);
    @(negedge Clk);
    b3.Start = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    int target = done_cnt0 + 1;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt0 >= target) break;
      @(negedge Clk);
    end
    chk("done0_timeout", 32'(done_cnt0 >= target), 1);
  endtask

  task automatic wait_done3(input int budget);
    int target = done_cnt3 + 1;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt3 >= target) break;
      @(negedge Clk);
    end
    chk("done3_timeout", 32'(done_cnt3 >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_hi;
    int dc;
    b0.Start = 1'b0; b0.TxData = '0; b0.Div = '0;
    b3.Start = 1'b0; b3.TxData = '0; b3.Div = '0;
    sw3 = '0;
    repeat (3) @(negedge Clk);
    chk("rst_cs0",   b0.CS_n, 1);
    chk("rst_sck0",  b0.SCK, 0);
    chk("rst_busy0", b0.Busy, 0);
    chk("rst_cpre0", b0.CPre, 0);
    chk("rst_sck3",  b3.SCK, 1);
    chk("rst_rx3",   b3.RxData, 0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // mode 0, Pulse tied high, loopback
    gap_mode = 0;
    start0(8'hA5);
    wait_done0(60);

    // mode 3 with prescaler divide-by-4
    start3(8'h3C, 8'hC3, 4'd3);
    chk("cpre3", b3.CPre, 3);
    wait_done3(300);

    // Start while busy with different word and divider must be ignored
    start3(8'h96, 8'h5A, 4'd3);
    repeat (10) @(negedge Clk);
    b3.Start = 1'b1; b3.TxData = 8'hFF; b3.Div = 4'd1;
    @(negedge Clk);
    b3.Start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("cpre3_ignored", b3.CPre, 3);
    wait_done3(300);

    // Start held high: back-to-back transfers
    @(negedge Clk);
    b0.TxData = 8'h01; b0.Start = 1'b1;
    q0.push_back('{tx: 8'h01, rx: 8'h01});
    @(negedge Clk);
    b0.TxData = 8'h80;
    q0.push_back('{tx: 8'h80, rx: 8'h80});
    wait_done0(60);
    cs_hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (b0.CS_n !== 1'b1) break;
      cs_hi++;
      @(negedge Clk);
    end
    chk("b2b_cs_high", cs_hi, 1);
    b0.Start = 1'b0;
    wait_done0(60);

    // irregular Pulse gaps
    gap_mode = 1;
    start0(8'hA5);
    wait_done0(400);
    start0(8'h3C);
    wait_done0(400);

    // async reset mid-transfer
    start0(8'h5A);
    repeat ($urandom_range(20, 40)) @(negedge Clk);
    chk("rst_mid_busy", b0.Busy, 1);
    @(posedge Clk);
    #3 Rst_n = 1'b0;
    #1;
    chk("arst_cs0",   b0.CS_n, 1);
    chk("arst_sck0",  b0.SCK, 0);
    chk("arst_mosi0", b0.MOSI, 0);
    chk("arst_busy0", b0.Busy, 0);
    chk("arst_done0", b0.Done, 0);
    chk("arst_rx0",   b0.RxData, 0);
    chk("arst_cpre0", b0.CPre, 0);
    chk("arst_rx3",   b3.RxData, 0);
    chk("arst_cpre3", b3.CPre, 0);
    q0.delete();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    dc = done_cnt0;
    repeat (60) @(negedge Clk);
    chk("no_done_after_rst", done_cnt0, dc);
    chk("cs_idle_after_rst", b0.CS_n, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
